// File: rtl/decoder3x8_seq.sv
// decoder3x8_seq: sequenced 3-to-8 decoder.
// Buffers 3-bit binary codes arriving over a valid/ready handshake in a small FIFO.
// Each code is then replayed as a registered one-hot 8-bit pulse. The pulse lasts
// HOLD_CYCLES cycles and is followed by GAP_CYCLES idle cycles.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        allows new codes to be popped; a pulse in progress always completes
//   in_valid  in_code is valid this cycle
//   in_code   binary code 0..7
//   in_ready  FIFO can accept (level < FIFO_DEPTH)
//   y         registered one-hot output, 0 outside a pulse
//   y_valid   high exactly while y != 0
//   busy      sequencer not idle
//   level     FIFO occupancy
module decoder3x8_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic [2:0]                    in_code,
  output logic                          in_ready,
  output logic [7:0]                    y,
  output logic                          y_valid,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW   = AddrW + 1;
  localparam int unsigned MaxCnt = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [2:0]      rd_code;
  logic            push;
  logic            pop;
  logic            can_load;

  // Pointers carry one extra MSB so that full and empty differ.
  assign level    = wptr_q - rptr_q;
  assign in_ready = (level < PtrW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign can_load = en && (level != '0);
  assign rd_code  = mem_q[rptr_q[AddrW-1:0]];
  assign busy     = (state_q != StIdle);

  // A pop happens exactly when the sequencer applies the load rule.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      StIdle:  pop = can_load;
      StDrive: pop = (cnt_q == '0) && (GAP_CYCLES == 0) && can_load;
      StGap:   pop = (cnt_q == '0) && can_load;
      default: pop = 1'b0;
    endcase
  end

  // Storage needs no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AddrW-1:0]] <= in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            y       <= 8'd1 << rd_code;
            y_valid <= 1'b1;
            cnt_q   <= HoldLoad;
            state_q <= StDrive;
          end
        end
        StDrive: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (GAP_CYCLES > 0) begin
            y       <= '0;
            y_valid <= 1'b0;
            cnt_q   <= GapLoad;
            state_q <= StGap;
          end else if (pop) begin
            // Back-to-back pulse with no zero cycle in between.
            y       <= 8'd1 << rd_code;
            y_valid <= 1'b1;
            cnt_q   <= HoldLoad;
          end else begin
            y       <= '0;
            y_valid <= 1'b0;
            state_q <= StIdle;
          end
        end
        StGap: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (pop) begin
            y       <= 8'd1 << rd_code;
            y_valid <= 1'b1;
            cnt_q   <= HoldLoad;
            state_q <= StDrive;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
